// File: rtl/uart_cmd_regs.sv
// uart_cmd_regs
// Parses ASCII register-write commands from the UART receiver and answers
// each completed or rejected command with a single ACK/NAK byte.
// A command is a letter ('A' + k selects register k), up to DIGITS decimal
// digits with optional spaces, then CR. Values above 2^DATA_W-1, too many
// digits, stray bytes or a stalled command produce a NAK and leave the
// registers untouched.
//
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   from_uart_valid one-cycle strobe, received byte available
//   from_uart_data  received byte
//   reg_out         flat register file, register k at [k*DATA_W +: DATA_W]
//   reg_wr          one-cycle pulse, bit k set when register k is written
//   tx_valid        response byte pending
//   tx_data         response byte, 'K' (0x4B) = ACK, 'E' (0x45) = NAK
//   tx_ready        TX engine takes the byte when tx_valid && tx_ready
//   resp_drop       one-cycle pulse, a response was lost to a full slot
module uart_cmd_regs #(
  parameter int                           NUM_REGS    = 2,
  parameter int                           DATA_W      = 8,
  parameter int                           DIGITS      = 3,
  parameter logic [NUM_REGS*DATA_W-1:0]   RESET_VAL   = {8'h9A, 8'h01},
  parameter int                           TIMEOUT_CYC = 25_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         from_uart_valid,
  input  logic [7:0]                   from_uart_data,
  output logic [NUM_REGS*DATA_W-1:0]   reg_out,
  output logic [NUM_REGS-1:0]          reg_wr,
  output logic                         tx_valid,
  output logic [7:0]                   tx_data,
  input  logic                         tx_ready,
  output logic                         resp_drop
);

  localparam int ACC_W = DATA_W + 4;
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [7:0]       CH_ACK   = 8'h4B;
  localparam logic [7:0]       CH_NAK   = 8'h45;
  localparam logic [7:0]       CH_SP    = 8'h20;
  localparam logic [7:0]       CH_CR    = 8'h0D;
  localparam logic [ACC_W-1:0] ACC_MAX  = {4'b0000, {DATA_W{1'b1}}};
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIGITS);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_DIG, S_COMMIT, S_ABORT} state_t;

  state_t                       state_q, state_d;
  logic                         rx_valid_q, rx_valid_d;
  logic [7:0]                   rx_data_q, rx_data_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [ACC_W-1:0]             acc_q, acc_d;
  logic                         ovf_q, ovf_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [TMR_W-1:0]             timer_q, timer_d;
  logic [NUM_REGS*DATA_W-1:0]   regs_q, regs_d;
  logic [NUM_REGS-1:0]          reg_wr_q, reg_wr_d;
  logic                         tx_valid_q, tx_valid_d;
  logic [7:0]                   tx_data_q, tx_data_d;
  logic                         resp_drop_q, resp_drop_d;

  logic                         letter_hit;
  logic [IDX_W-1:0]             letter_idx;
  logic                         is_digit;
  logic [ACC_W-1:0]             acc_next;
  logic                         resp_push;
  logic [7:0]                   resp_byte;

  // Byte classification on the registered input byte. The accumulator is
  // wide enough that (2^DATA_W-1)*10+9 never wraps, so the range check on
  // acc_next is exact.
  always_comb begin
    letter_hit = 1'b0;
    letter_idx = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rx_data_q == 8'(65 + k)) begin
        letter_hit = 1'b1;
        letter_idx = IDX_W'(k);
      end
    end
    is_digit = (rx_data_q >= 8'h30) && (rx_data_q <= 8'h39);
    acc_next = acc_q * ACC_W'(10) + {{(ACC_W-4){1'b0}}, rx_data_q[3:0]};
  end

  // Command FSM plus response slot. The input byte is registered first, so
  // the FSM reacts one cycle after the byte is sampled. The idle timer is
  // cleared straight from the raw strobe and saturates, which keeps the
  // timeout measured from the moment the byte was sampled.
  always_comb begin
    rx_valid_d  = from_uart_valid;
    rx_data_d   = from_uart_data;
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    count_d     = count_q;
    regs_d      = regs_q;
    reg_wr_d    = '0;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    resp_drop_d = 1'b0;
    resp_push   = 1'b0;
    resp_byte   = CH_NAK;

    if (from_uart_valid) begin
      timer_d = '0;
    end else if (timer_q == TMR_LAST) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TMR_W'(1);
    end

    if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid_q && letter_hit) begin
          idx_d   = letter_idx;
          acc_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          state_d = S_SEL;
        end
      end
      S_SEL, S_DIG: begin
        if (rx_valid_q) begin
          if (rx_data_q == CH_SP) begin
            state_d = state_q;
          end else if (is_digit) begin
            if (count_q == CNT_MAX) begin
              state_d = S_ABORT;
            end else begin
              count_d = count_q + CNT_W'(1);
              state_d = S_DIG;
              if (!ovf_q) begin
                if (acc_next > ACC_MAX) begin
                  ovf_d = 1'b1;
                end else begin
                  acc_d = acc_next;
                end
              end
            end
          end else if (rx_data_q == CH_CR) begin
            state_d = (state_q == S_DIG) ? S_COMMIT : S_ABORT;
          end else begin
            state_d = S_ABORT;
          end
        end else if (timer_q == TMR_LAST) begin
          state_d = S_ABORT;
        end
      end
      S_COMMIT: begin
        resp_push = 1'b1;
        if (ovf_q) begin
          resp_byte = CH_NAK;
        end else begin
          resp_byte = CH_ACK;
          for (int k = 0; k < NUM_REGS; k++) begin
            if (idx_q == IDX_W'(k)) begin
              regs_d[k*DATA_W +: DATA_W] = acc_q[DATA_W-1:0];
              reg_wr_d[k]                = 1'b1;
            end
          end
        end
        state_d = S_IDLE;
      end
      S_ABORT: begin
        resp_push = 1'b1;
        resp_byte = CH_NAK;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Single-entry slot: a byte being consumed this cycle frees the slot
    // for the new response; otherwise a pending byte wins and the new one
    // is dropped.
    if (resp_push) begin
      if (tx_valid_q && !tx_ready) begin
        resp_drop_d = 1'b1;
      end else begin
        tx_valid_d = 1'b1;
        tx_data_d  = resp_byte;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      idx_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      timer_q     <= '0;
      regs_q      <= RESET_VAL;
      reg_wr_q    <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      resp_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      regs_q      <= regs_d;
      reg_wr_q    <= reg_wr_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      resp_drop_q <= resp_drop_d;
    end
  end

  assign reg_out   = regs_q;
  assign reg_wr    = reg_wr_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign resp_drop = resp_drop_q;

endmodule
